// File: rtl/adc_lvds_tx_emulator.sv
// Transmit-side emulator for the 2-lane 16-bit serial ADC link: two SDR data lanes plus FCO, 8 clk per frame.
// Define ADC_TX_PRBS_EN to turn mode 11 into a PRBS-15 source instead of the AAAA/5555 alternate pattern.
module adc_lvds_tx_emulator #(
  parameter int unsigned SKEW_INIT  = 0,
  parameter logic [15:0] FIXED_PAT  = 16'hA5C3,
  parameter int unsigned UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  skew_inc,
  output logic [2:0]            skew,
  output logic                  lane0,
  output logic                  lane1,
  output logic                  fco,
  output logic                  frame_start,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned HALF_W = WORD_W / 2;
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_RAMP   = 2'b01;
  localparam logic [1:0] MODE_FIXED  = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic [HALF_W-2:0]     sh0_q, sh0_d, sh1_q, sh1_d;
  logic [HALF_W-1:0]     line0_q, line0_d, line1_q, line1_d;
  logic [WORD_W-1:0]     last_q, last_d, ramp_q, ramp_d, word_c;
  logic [2:0]            skew_d;
  logic [UNDERRUN_W-1:0] under_d;
  logic                  lane0_d, lane1_d, fco_d, fs_d;
  logic                  load_pt_c, load_c;

`ifdef ADC_TX_PRBS_EN
  localparam int unsigned LFSR_W = 15;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv_c;
  logic [WORD_W-1:0] prbs_word_c;

  // Sixteen steps of x^15+x^14+1; the first output bit becomes the word MSB
  always_comb begin
    lfsr_adv_c  = lfsr_q;
    prbs_word_c = '0;
    for (int i = 0; i < WORD_W; i++) begin
      prbs_word_c = {prbs_word_c[WORD_W-2:0], lfsr_adv_c[LFSR_W-1] ^ lfsr_adv_c[LFSR_W-2]};
      lfsr_adv_c  = {lfsr_adv_c[LFSR_W-2:0], lfsr_adv_c[LFSR_W-1] ^ lfsr_adv_c[LFSR_W-2]};
    end
  end
`else
  logic alt_q, alt_d;
`endif

  assign load_pt_c = (state_q == IDLE) ? en : (phase_q == 3'd7);
  assign load_c    = load_pt_c & en;
  assign s_ready   = rst_n & load_c & (mode == MODE_NORMAL);

  always_comb begin
    word_c = last_q;
    case (mode)
      MODE_NORMAL: word_c = s_valid ? s_data : last_q;
      MODE_RAMP:   word_c = ramp_q;
      MODE_FIXED:  word_c = FIXED_PAT;
`ifdef ADC_TX_PRBS_EN
      default:     word_c = prbs_word_c;
`else
      default:     word_c = alt_q ? 16'h5555 : 16'hAAAA;
`endif
    endcase
  end

  // Next state; line*_d[0] is the undelayed lane bit, higher taps are older bits
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sh0_d   = {sh0_q[HALF_W-3:0], 1'b0};
    sh1_d   = {sh1_q[HALF_W-3:0], 1'b0};
    line0_d = {line0_q[HALF_W-2:0], sh0_q[HALF_W-2]};
    line1_d = {line1_q[HALF_W-2:0], sh1_q[HALF_W-2]};
    last_d  = last_q;
    ramp_d  = ramp_q;
    under_d = underrun_cnt;
    skew_d  = skew + 3'(skew_inc);
`ifdef ADC_TX_PRBS_EN
    lfsr_d  = lfsr_q;
`else
    alt_d   = alt_q;
`endif
    if (load_c) begin
      state_d    = RUN;
      phase_d    = 3'd0;
      line1_d[0] = word_c[15];
      line0_d[0] = word_c[14];
      sh1_d = {word_c[13], word_c[11], word_c[9], word_c[7], word_c[5], word_c[3], word_c[1]};
      sh0_d = {word_c[12], word_c[10], word_c[8], word_c[6], word_c[4], word_c[2], word_c[0]};
      case (mode)
        MODE_NORMAL: begin
          if (s_valid) last_d = s_data;
          else if (~&underrun_cnt) under_d = underrun_cnt + UNDERRUN_W'(1);
        end
        MODE_RAMP:  ramp_d = ramp_q + 16'd1;
        MODE_FIXED: ;
`ifdef ADC_TX_PRBS_EN
        default:    lfsr_d = lfsr_adv_c;
`else
        default:    alt_d = ~alt_q;
`endif
      endcase
    end else if (state_q == RUN) begin
      if (phase_q == 3'd7) state_d = IDLE;
      else phase_d = phase_q + 3'd1;
    end
    lane0_d = line0_d[skew_d];
    lane1_d = line1_d[skew_d];
    fco_d   = (state_d == RUN) & ~phase_d[2];
    fs_d    = (state_d == RUN) & (phase_d == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= 3'd7;
      sh0_q        <= '0;
      sh1_q        <= '0;
      line0_q      <= '0;
      line1_q      <= '0;
      last_q       <= '0;
      ramp_q       <= '0;
      skew         <= 3'(SKEW_INIT);
      underrun_cnt <= '0;
      lane0        <= 1'b0;
      lane1        <= 1'b0;
      fco          <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sh0_q        <= sh0_d;
      sh1_q        <= sh1_d;
      line0_q      <= line0_d;
      line1_q      <= line1_d;
      last_q       <= last_d;
      ramp_q       <= ramp_d;
      skew         <= skew_d;
      underrun_cnt <= under_d;
      lane0        <= lane0_d;
      lane1        <= lane1_d;
      fco          <= fco_d;
      frame_start  <= fs_d;
    end
  end

`ifdef ADC_TX_PRBS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_W'(1);
    else        lfsr_q <= lfsr_d;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alt_q <= 1'b0;
    else        alt_q <= alt_d;
  end
`endif

endmodule

// File: tb/tb_adc_lvds_tx_emulator.sv
// Bench for adc_lvds_tx_emulator: vector table, directed corner sequences and random traffic
// checked cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_adc_lvds_tx_emulator;
  localparam int unsigned UW    = 4;
  localparam int unsigned SKEW0 = 0;
  localparam logic [15:0] FPAT  = 16'hA5C3;
  localparam int          UMAX  = (1 << UW) - 1;
  localparam int          NV    = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, s_valid, s_ready, skew_inc;
  logic          lane0, lane1, fco, frame_start;
  logic [1:0]    mode;
  logic [15:0]   s_data;
  logic [2:0]    skew;
  logic [UW-1:0] underrun_cnt;

  int tests  = 0;
  int failed = 0;

  adc_lvds_tx_emulator #(
    .SKEW_INIT(SKEW0), .FIXED_PAT(FPAT), .UNDERRUN_W(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .skew_inc(skew_inc), .skew(skew),
    .lane0(lane0), .lane1(lane1), .fco(fco), .frame_start(frame_start),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame position, chosen word, bit history ----------------
  int          m_pos, m_skew, m_under;
  logic [15:0] m_word, m_last, m_ramp;
  bit          m_alt, m_lp, fb;
  logic [14:0] m_lfsr;
  bit          q0[$], q1[$];

  function void m_reset();
    m_pos = -1; m_skew = SKEW0; m_under = 0;
    m_word = '0; m_last = '0; m_ramp = '0; m_alt = 0; m_lfsr = 15'd1;
    q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) begin q0.push_back(0); q1.push_back(0); end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_lane0", lane0, 0);
      chk("rst_lane1", lane1, 0);
      chk("rst_fco", fco, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_skew", skew, SKEW0);
      chk("rst_under", underrun_cnt, 0);
      m_reset();
    end else begin
      q1.push_front(m_pos >= 0 ? m_word[15-2*m_pos] : 1'b0);
      q0.push_front(m_pos >= 0 ? m_word[14-2*m_pos] : 1'b0);
      void'(q1.pop_back());
      void'(q0.pop_back());
      m_lp = (m_pos < 0) ? en : (m_pos == 7);
      chk("lane1", lane1, q1[m_skew]);
      chk("lane0", lane0, q0[m_skew]);
      chk("fco", fco, (m_pos >= 0 && m_pos < 4));
      chk("frame_start", frame_start, (m_pos == 0));
      chk("s_ready", s_ready, (m_lp && en && mode == 2'b00));
      chk("skew", skew, m_skew);
      chk("underrun", underrun_cnt, m_under);
      if (m_lp && en) begin
        case (mode)
          2'b00: begin
            if (s_valid) begin m_word = s_data; m_last = s_data; end
            else begin m_word = m_last; if (m_under < UMAX) m_under++; end
          end
          2'b01: begin m_word = m_ramp; m_ramp = m_ramp + 16'd1; end
          2'b10: m_word = FPAT;
          default: begin
`ifdef ADC_TX_PRBS_EN
            for (int k = 0; k < 16; k++) begin
              fb = m_lfsr[14] ^ m_lfsr[13];
              m_word = {m_word[14:0], fb};
              m_lfsr = {m_lfsr[13:0], fb};
            end
`else
            m_word = m_alt ? 16'h5555 : 16'hAAAA;
            m_alt = !m_alt;
`endif
          end
        endcase
        m_pos = 0;
      end else if (m_lp) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
      m_skew = (m_skew + int'(skew_inc)) % 8;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [1:0]  mode;
    logic        valid;
    logic [15:0] data;
    logic [15:0] exp_word;
    logic        exp_ready;
    int          exp_under;
  } vec_t;

  vec_t        tab [NV];
  logic [7:0]  w0, w1;
  logic        found;

  function automatic logic [15:0] deint(input logic [7:0] o, input logic [7:0] e);
    logic [15:0] r;
    for (int k = 0; k < 8; k++) begin
      r[15-2*k] = o[7-k];
      r[14-2*k] = e[7-k];
    end
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_fs(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = frame_start;
    end
    chk("frame_start_seen", seen, 1);
  endtask

  task automatic pulse_skew(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 skew_inc = 1'b1;
      @(posedge clk); #1 skew_inc = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; s_data = '0; s_valid = 1'b0; skew_inc = 1'b0;
    tab[0] = '{2'b00, 1'b1, 16'h8001, 16'h8001, 1'b1, 0};
    tab[1] = '{2'b00, 1'b1, 16'h1234, 16'h1234, 1'b1, 0};
    tab[2] = '{2'b00, 1'b0, 16'hBEEF, 16'h1234, 1'b1, 1};
    tab[3] = '{2'b10, 1'b1, 16'h0000, FPAT,     1'b0, 1};
`ifdef ADC_TX_PRBS_EN
    tab[4] = '{2'b11, 1'b0, 16'h0000, 16'h0006, 1'b0, 1};
`else
    tab[4] = '{2'b11, 1'b0, 16'h0000, 16'hAAAA, 1'b0, 1};
`endif
    tab[5] = '{2'b01, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1};
    tab[6] = '{2'b01, 1'b0, 16'h0000, 16'h0001, 1'b0, 1};
    tab[7] = '{2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1};

    // Back-to-back frames, one table entry per load point
    do_reset();
    en = 1'b1;
    w0 = '0; w1 = '0;
    for (int c = 0; c <= 8 * NV; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c % 8 == 0 && c / 8 < NV) begin
        mode = tab[c/8].mode; s_valid = tab[c/8].valid; s_data = tab[c/8].data;
      end
      @(negedge clk);
      if (c > 0) begin w1 = {w1[6:0], lane1}; w0 = {w0[6:0], lane0}; end
      if (c % 8 == 0 && c / 8 < NV) chk("vec_ready", s_ready, tab[c/8].exp_ready);
      if (c > 0 && c % 8 == 0) begin
        chk("vec_word", deint(w1, w0), tab[c/8-1].exp_word);
        chk("vec_under", underrun_cnt, tab[c/8-1].exp_under);
      end
    end

    // Underrun counter saturation
    do_reset();
    en = 1'b1; mode = 2'b00; s_valid = 1'b1; s_data = 16'h1234;
    @(posedge clk); #1 s_valid = 1'b0;
    repeat (8 * 20) @(posedge clk);
    @(negedge clk);
    chk("under_sat", underrun_cnt, UMAX);

    // Skew: three pulses then lanes lag FCO by three bits; eight pulses wrap back
    do_reset();
    en = 1'b1; mode = 2'b10;
    pulse_skew(3);
    @(negedge clk);
    chk("skew_3", skew, 3);
    wait_fs(found);
    repeat (2) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      w1 = {w1[6:0], lane1}; w0 = {w0[6:0], lane0};
    end
    chk("skew_3_word", deint(w1, w0), FPAT);
    pulse_skew(5);
    @(negedge clk);
    chk("skew_wrap", skew, SKEW0);

    // en dropped at phase 2: frame completes, then IDLE
    do_reset();
    en = 1'b1; mode = 2'b10;
    wait_fs(found);
    w1 = {7'd0, lane1}; w0 = {7'd0, lane0};
    @(posedge clk); #1;
    @(negedge clk);
    w1 = {w1[6:0], lane1}; w0 = {w0[6:0], lane0};
    @(posedge clk); #1 en = 1'b0;
    for (int p = 2; p < 8; p++) begin
      @(negedge clk);
      w1 = {w1[6:0], lane1}; w0 = {w0[6:0], lane0};
      chk("drop_fco", fco, (p < 4));
    end
    chk("drop_word", deint(w1, w0), FPAT);
    @(negedge clk);
    chk("idle_fco", fco, 0);
    chk("idle_fs", frame_start, 0);
    chk("idle_ready", s_ready, 0);

    // Async reset in the middle of a frame clears outputs immediately
    en = 1'b1;
    wait_fs(found);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_lane1", lane1, 0);
    chk("async_lane0", lane0, 0);
    chk("async_fco", fco, 0);
    chk("async_ready", s_ready, 0);
    chk("async_skew", skew, SKEW0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      en       = ($urandom_range(0, 9) != 0);
      mode     = 2'($urandom_range(0, 3));
      s_valid  = ($urandom_range(0, 9) < 7);
      s_data   = 16'($urandom);
      skew_inc = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1 skew_inc = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/adc_lvds_tx_emulator.md
Name: adc_lvds_tx_emulator

Overview:
- Transmit-side model of the 2-lane, 16-bit serial ADC link: serializes parallel samples onto two data lanes plus a frame-clock (FCO) lane in the format the ADC receive path deserializes.
- Loop-back/bring-up source driving the receiver's frame detector, bitslip aligner and per-ADC deserializers.
- Programmable data-to-FCO skew exercises receiver bitslip alignment.
- One bit per clk per lane (SDR); 8 clk per frame.

Parameters:
- SKEW_INIT, 0: data-lane delay (bits) relative to FCO after reset, 0..7.
- FIXED_PAT, 16'hA5C3: word sent in fixed-pattern mode.
- UNDERRUN_W, 16: width of the underrun counter.

Ports:
- clk  in  1  bit clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- mode  in  2  00 normal, 01 ramp, 10 fixed, 11 alternate.
- s_data  in  16  sample word.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- skew_inc  in  1  single-cycle pulse: skew += 1 mod 8.
- skew  out  3  current skew.
- lane0  out  1  even bits D14,D12,..,D0, MSB first.
- lane1  out  1  odd bits D15,D13,..,D1, MSB first.
- fco  out  1  frame clock, pattern 1111_0000 per frame.
- frame_start  out  1  pulse on the first bit of each frame (FCO timing).
- underrun_cnt  out  UNDERRUN_W  saturating count of frames with no sample.

Behaviour:
- Reset (async, rst_n=0): state IDLE, phase=7, shift regs 0, last word 0, delay lines 0, skew=SKEW_INIT, ramp=0, alt toggle=0, underrun_cnt=0. Outputs lane0=lane1=fco=frame_start=s_ready=0.
- States:
  - IDLE: phase held at 7, fco=0, lanes shift zeros.
  - RUN: phase counts 0..7 and wraps.
- Load point: IDLE with en=1, or RUN with phase=7.
  - en=1 at load point: next cycle is RUN phase 0 with the new word in the shift registers.
  - en=0 at load point: go/stay IDLE.
  - en dropped mid-frame: the current frame completes, then IDLE.
- s_ready = (load point) & en & (mode==00), combinational. No other cycle accepts data.
- Word selection at load point:
  - Normal: s_data if s_valid, else repeat last word and underrun_cnt += 1, saturating at all-ones.
  - Ramp: ramp value; ramp += 1 per frame, wraps FFFF->0000.
  - Fixed: FIXED_PAT.
  - Alternate: AAAA / 5555, starting AAAA after reset; toggles each frame.
  - Pattern modes never count underruns.
- Latency: word accepted at cycle t gives lane1=D15, lane0=D14 at t+1 (skew 0); last bits D1/D0 at t+8.
- fco=1 at phases 0-3, 0 at phases 4-7. frame_start=1 at phase 0. Both undelayed.
- Skew: each lane passes through an 8-deep delay line; output tap = skew (0 means no delay). skew_inc increments 7->0 (wrap). New tap takes effect the cycle after the pulse, with no pipeline flush.
- mode change: sampled only at load points; never corrupts a frame in flight.
- skew_inc coincident with the load point: both take effect independently.

Optional Feature:
- ADC_TX_PRBS_EN defined: mode 11 becomes PRBS-15 (x^15+x^14+1, seed 0x0001). Each frame's 16-bit word is 16 successive LFSR outputs, MSB first. The LFSR advances only in mode 11 frames and resets to the seed on rst_n.
- Undefined: mode 11 = alternate AAAA/5555. No LFSR logic synthesized.

Test Plan:
1. Reset, en=1, mode=00, s_valid held with s_data=16'h8001, skew 0 -> s_ready pulses every 8 cycles; lane1 = 1000_0000 and lane0 = 0000_0001 per frame; fco = 1111_0000; frame_start coincides with lane1 bit D15.
2. Normal mode, s_valid=0 for 3 load points after sending 16'h1234 -> 16'h1234 repeated 3 times; underrun_cnt=3.
3. Ramp mode for 4 frames from reset -> deserialized words 0000, 0001, 0002, 0003; s_ready stays 0.
4. Fixed mode, 3 skew_inc pulses -> skew=3; lanes lag fco by exactly 3 clk; 8 total pulses return skew to SKEW_INIT.
5. en dropped at phase 2 -> frame finishes through phase 7; IDLE follows with fco=0 and s_ready=0. rst_n asserted mid-frame instead -> all outputs 0 in the same cycle (async).
6. Mode 11 -> AAAA/5555 alternating. With ADC_TX_PRBS_EN defined, the first frame is the first 16 PRBS-15 bits from seed 0x0001.
